reset_watchdog: RTL and testbench

- Watchdog timer that drives the active-low external reset request into the clock/reset generator (`reset_ext` input there).
- Software must kick it periodically. On timeout or an explicit software request, it emits a clean, fixed-width active-low reset pulse.
- It records the cause of the reset in a sticky register.
- It must be clocked on the board clock and reset only by the board power-on reset, never by the `resetn` it causes. This lets the cause survive the system reset.

---
 rtl/reset_watchdog.sv | 163 ++++++++++++++++
 tb/tb_reset_watchdog.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_watchdog.sv
// Reset watchdog: counts down from TIMEOUT_CYCLES-1 while armed and, on expiry
// or a software request, drives a fixed-width active-low reset request pulse
// followed by a holdoff period. The cause of the last firing is kept in a
// sticky register. Clock and reset come from the board, never from the reset
// this block requests, so the cause survives the system reset.
// Optional build macro: WDT_WINDOW_EN turns it into a window watchdog. Kicks
// above WINDOW_OPEN then count as early kicks and fire with cause 11.

module reset_watchdog #(
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned TIMEOUT_CYCLES = 12000000,
  parameter int unsigned PULSE_CYCLES   = 16,
  parameter int unsigned HOLDOFF_CYCLES = 256,
  parameter int unsigned WINDOW_OPEN    = 6000000
) (
  input  logic             clock_in,
  input  logic             resetn,
  input  logic             enable,
  input  logic             kick,
  input  logic             sw_reset_req,
  input  logic             clear_cause,
  output logic             reset_req_n,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] count,
  output logic             armed
);

  localparam int unsigned PH_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LIMIT  = CNT_W'(WINDOW_OPEN);
  localparam logic [PH_W-1:0]  PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(HOLDOFF_CYCLES - 1);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_SW      = 2'b10;
  localparam logic [1:0] CAUSE_EARLY   = 2'b11;

`ifdef WDT_WINDOW_EN
  localparam bit WINDOW_EN = 1'b1;
`else
  localparam bit WINDOW_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_ARMED    = 2'd1,
    S_FIRING   = 2'd2,
    S_HOLDOFF  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PH_W-1:0]  ph_q;
  logic [1:0]       cause_q;
  logic             req_n_q;
  logic             armed_q;

  // Early kick: only possible in the window build, when the counter is still above the window
  logic early_kick_c;
  assign early_kick_c = WINDOW_EN && (cnt_q > WIN_LIMIT);

  // Watchdog FSM with all outputs held in flops
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_DISABLED;
      cnt_q   <= '0;
      ph_q    <= '0;
      cause_q <= CAUSE_NONE;
      req_n_q <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      // Clear request first so that a simultaneous firing entry overrides it
      if (clear_cause && (state_q != S_FIRING)) begin
        cause_q <= CAUSE_NONE;
      end

      case (state_q)
        S_DISABLED: begin
          if (sw_reset_req) begin
            state_q <= S_FIRING;
            cause_q <= CAUSE_SW;
            req_n_q <= 1'b0;
            ph_q    <= PULSE_LAST;
          end else if (enable) begin
            state_q <= S_ARMED;
            cnt_q   <= RELOAD;
            armed_q <= 1'b1;
          end
        end

        S_ARMED: begin
          if (sw_reset_req) begin
            state_q <= S_FIRING;
            cause_q <= CAUSE_SW;
            req_n_q <= 1'b0;
            ph_q    <= PULSE_LAST;
            armed_q <= 1'b0;
          end else if (!enable) begin
            state_q <= S_DISABLED;
            cnt_q   <= '0;
            armed_q <= 1'b0;
          end else if (kick && early_kick_c) begin
            state_q <= S_FIRING;
            cause_q <= CAUSE_EARLY;
            req_n_q <= 1'b0;
            ph_q    <= PULSE_LAST;
            armed_q <= 1'b0;
          end else if (kick) begin
            cnt_q <= RELOAD;
          end else if (cnt_q == '0) begin
            state_q <= S_FIRING;
            cause_q <= CAUSE_TIMEOUT;
            req_n_q <= 1'b0;
            ph_q    <= PULSE_LAST;
            armed_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_FIRING: begin
          if (ph_q == '0) begin
            state_q <= S_HOLDOFF;
            req_n_q <= 1'b1;
            ph_q    <= HOLD_LAST;
          end else begin
            ph_q <= ph_q - PH_W'(1);
          end
        end

        S_HOLDOFF: begin
          if (ph_q == '0) begin
            if (enable) begin
              state_q <= S_ARMED;
              cnt_q   <= RELOAD;
              armed_q <= 1'b1;
            end else begin
              state_q <= S_DISABLED;
              cnt_q   <= '0;
            end
          end else begin
            ph_q <= ph_q - PH_W'(1);
          end
        end

        default: begin
          state_q <= S_DISABLED;
          req_n_q <= 1'b1;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

  assign reset_req_n = req_n_q;
  assign cause       = cause_q;
  assign count       = cnt_q;
  assign armed       = armed_q;

endmodule

// File: tb/tb_reset_watchdog.sv
// Directed bench for reset_watchdog with TIMEOUT=100, PULSE=16, HOLDOFF=8, WINDOW_OPEN=40.
// Inputs change 1 time unit after a rising edge; outputs are checked at that point.

module tb_reset_watchdog;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned PULSE   = 16;
  localparam int unsigned HOLDOFF = 8;
  localparam int unsigned WINDOW  = 40;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             kick;
  logic             sw_reset_req;
  logic             clear_cause;
  logic             reset_req_n;
  logic [1:0]       cause;
  logic [CNT_W-1:0] count;
  logic             armed;

  int checks;
  int errors;

  reset_watchdog #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT),
    .PULSE_CYCLES   (PULSE),
    .HOLDOFF_CYCLES (HOLDOFF),
    .WINDOW_OPEN    (WINDOW)
  ) dut (
    .clock_in     (clk),
    .resetn       (rst_n),
    .enable       (enable),
    .kick         (kick),
    .sw_reset_req (sw_reset_req),
    .clear_cause  (clear_cause),
    .reset_req_n  (reset_req_n),
    .cause        (cause),
    .count        (count),
    .armed        (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts consecutive low cycles of reset_req_n starting from the current (low) cycle
  task automatic measure_low(output int low_cnt);
    low_cnt = 0;
    while (reset_req_n === 1'b0 && low_cnt < 40) begin
      low_cnt++;
      tick();
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n        = 1'b0;
    enable       = 1'b0;
    kick         = 1'b0;
    sw_reset_req = 1'b0;
    clear_cause  = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({reset_req_n, cause, count, armed} !== {1'b1, 2'b00, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got req_n=%b cause=%b count=%0d armed=%b want 1/00/0/0",
               reset_req_n, cause, count, armed);
    end
  endtask

  task automatic test_timeout();
    int lows;
    do_reset();
    enable = 1'b1;
    tick();
    checks++;
    if (armed !== 1'b1 || count !== 8'd99) begin
      errors++;
      $display("FAIL arm: armed=%b count=%0d want 1/99", armed, count);
    end
    tick(99);
    checks++;
    if (count !== 8'd0 || reset_req_n !== 1'b1) begin
      errors++;
      $display("FAIL expiry_edge99: count=%0d req_n=%b want 0/1", count, reset_req_n);
    end
    tick();
    checks++;
    if (reset_req_n !== 1'b0 || cause !== 2'b01 || armed !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: req_n=%b cause=%b armed=%b want 0/01/0", reset_req_n, cause, armed);
    end
    measure_low(lows);
    checks++;
    if (lows != 16) begin
      errors++;
      $display("FAIL timeout_pulse_width: got %0d want 16", lows);
    end
    tick(7);
    checks++;
    if (reset_req_n !== 1'b1 || armed !== 1'b0) begin
      errors++;
      $display("FAIL holdoff_end: req_n=%b armed=%b want 1/0", reset_req_n, armed);
    end
    tick();
    checks++;
    if (armed !== 1'b1 || count !== 8'd99 || cause !== 2'b01) begin
      errors++;
      $display("FAIL rearm: armed=%b count=%0d cause=%b want 1/99/01", armed, count, cause);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_kick();
    int min_cnt;
    bit saw_low;
    do_reset();
    enable  = 1'b1;
    tick();
    min_cnt = 255;
    saw_low = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      kick = ((i % 50) == 49);
      tick();
      kick = 1'b0;
      if (reset_req_n !== 1'b1) saw_low = 1'b1;
      if (int'(count) < min_cnt) min_cnt = int'(count);
    end
    checks++;
    if (saw_low || cause !== 2'b00) begin
      errors++;
      $display("FAIL kick_keepalive: saw_low=%0d cause=%b want 0/00", saw_low, cause);
    end
    checks++;
    if (min_cnt < 49) begin
      errors++;
      $display("FAIL kick_min_count: got %0d want >=49", min_cnt);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_sw_reset();
    int lows;
    do_reset();
    sw_reset_req = 1'b1;
    clear_cause  = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    clear_cause  = 1'b0;
    checks++;
    if (reset_req_n !== 1'b0 || cause !== 2'b10) begin
      errors++;
      $display("FAIL sw_fire: req_n=%b cause=%b want 0/10", reset_req_n, cause);
    end
    clear_cause = 1'b1;
    tick();
    clear_cause = 1'b0;
    checks++;
    if (cause !== 2'b10) begin
      errors++;
      $display("FAIL clear_in_firing: cause=%b want 10", cause);
    end
    measure_low(lows);
    checks++;
    if (lows != 15) begin
      errors++;
      $display("FAIL sw_pulse_width: remaining low %0d want 15", lows);
    end
    tick(8);
    checks++;
    if (armed !== 1'b0 || reset_req_n !== 1'b1 || count !== 8'd0 || cause !== 2'b10) begin
      errors++;
      $display("FAIL sw_after_holdoff: armed=%b req_n=%b count=%0d cause=%b want 0/1/0/10",
               armed, reset_req_n, count, cause);
    end
    clear_cause = 1'b1;
    tick();
    clear_cause = 1'b0;
    checks++;
    if (cause !== 2'b00) begin
      errors++;
      $display("FAIL clear_cause: cause=%b want 00", cause);
    end
  endtask

  task automatic test_zero_boundary();
    do_reset();
    enable = 1'b1;
    tick(100);
    kick = 1'b1;
    tick();
    kick = 1'b0;
    checks++;
    if (count !== 8'd99 || reset_req_n !== 1'b1 || armed !== 1'b1) begin
      errors++;
      $display("FAIL kick_at_zero: count=%0d req_n=%b armed=%b want 99/1/1", count, reset_req_n, armed);
    end
    tick(99);
    enable = 1'b0;
    tick();
    checks++;
    if (armed !== 1'b0 || reset_req_n !== 1'b1 || count !== 8'd0) begin
      errors++;
      $display("FAIL disable_at_zero: armed=%b req_n=%b count=%0d want 0/1/0", armed, reset_req_n, count);
    end
    tick(5);
    checks++;
    if (reset_req_n !== 1'b1 || cause !== 2'b00) begin
      errors++;
      $display("FAIL disable_no_fire: req_n=%b cause=%b want 1/00", reset_req_n, cause);
    end
  endtask

  task automatic test_async_reset();
    bit saw_low;
    do_reset();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    tick(4);
    checks++;
    if (reset_req_n !== 1'b0) begin
      errors++;
      $display("FAIL fifth_low_cycle: req_n=%b want 0", reset_req_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({reset_req_n, cause, count, armed} !== {1'b1, 2'b00, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: req_n=%b cause=%b count=%0d armed=%b want 1/00/0/0",
               reset_req_n, cause, count, armed);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (reset_req_n !== 1'b1 || armed !== 1'b0) saw_low = 1'b1;
    end
    checks++;
    if (saw_low) begin
      errors++;
      $display("FAIL post_reset_quiet: extra activity seen, want none");
    end
  endtask

  task automatic test_window();
    do_reset();
    enable = 1'b1;
    tick();
    tick(39);
    kick = 1'b1;
    tick();
    kick = 1'b0;
`ifdef WDT_WINDOW_EN
    checks++;
    if (reset_req_n !== 1'b0 || cause !== 2'b11) begin
      errors++;
      $display("FAIL early_kick: req_n=%b cause=%b want 0/11", reset_req_n, cause);
    end
    tick(24);
    checks++;
    if (armed !== 1'b1 || count !== 8'd99) begin
      errors++;
      $display("FAIL early_rearm: armed=%b count=%0d want 1/99", armed, count);
    end
`else
    checks++;
    if (reset_req_n !== 1'b1 || count !== 8'd99 || cause !== 2'b00) begin
      errors++;
      $display("FAIL kick_at_60: req_n=%b count=%0d cause=%b want 1/99/00", reset_req_n, count, cause);
    end
`endif
    tick(69);
    checks++;
    if (count !== 8'd30) begin
      errors++;
      $display("FAIL window_setup: count=%0d want 30", count);
    end
    kick = 1'b1;
    tick();
    kick = 1'b0;
    checks++;
    if (reset_req_n !== 1'b1 || count !== 8'd99) begin
      errors++;
      $display("FAIL kick_at_30: req_n=%b count=%0d want 1/99", reset_req_n, count);
    end
    enable = 1'b0;
    tick();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    kick         = 1'b0;
    sw_reset_req = 1'b0;
    clear_cause  = 1'b0;
    test_reset();
    test_timeout();
    test_kick();
    test_sw_reset();
    test_zero_boundary();
    test_async_reset();
    test_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
